// File: rtl/primogen_arb_pkg.sv
// Shared definitions for the primogen round-robin arbiter: FSM state encoding
// and the requester-index width helper.
package primogen_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        GAP   = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_e;

    // Ceiling log2, never below 1 so a 2-requester build still has an index bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/primogen_arb_rr_pick.sv
// Combinational round-robin picker: first set request bit strictly after ptr,
// wrapping around, so the previous winner has the lowest priority.
module rr_pick
    import primogen_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;
    logic          hit;

    // Walk candidates ptr+1 .. ptr+N; only the first hit updates idx.
    always_comb begin
        valid = 1'b0;
        idx   = {IW{1'b0}};
        cand  = {IW{1'b0}};
        hit   = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand  = IW'((int'(ptr) + i) % N);
            hit   = ~valid & req[cand];
            idx   = hit ? cand : idx;
            valid = valid | hit;
        end
    end

endmodule

// File: rtl/primogen_arb.sv
// Round-robin arbiter sharing one primogen instance between N requesters.
// Optional WAIT timeout enabled by defining PRIMOGEN_ARB_TIMEOUT_EN.
module primogen_arb
    import primogen_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] done,
    output logic [W-1:0] res_out,
    output logic         err_out,
    output logic         busy,
    output logic         pg_go,
    input  logic         pg_rdy,
    input  logic         pg_err,
    input  logic [W-1:0] pg_res
);

    localparam int            IW      = clog2(N);
    localparam logic [IW-1:0] PTR_RST = IW'(N - 1);
    localparam logic [N-1:0]  ONE_HOT = {{(N-1){1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [W-1:0]  res_q, res_d;
    logic          err_q, err_d;
    logic [N-1:0]  done_q, done_d;
    logic          go_q, go_d;
    logic          busy_q, busy_d;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;

`ifdef PRIMOGEN_ARB_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_CNT = 32'(TIMEOUT);
    logic [31:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^(32'(TIMEOUT));
`endif

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        res_d   = res_q;
        err_d   = err_q;
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid && pg_rdy) begin
                    idx_d = pick_idx;
                    ptr_d = pick_idx;
                    // primogen error is sticky, so answer at once without a go pulse
                    if (pg_err) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: state_d = GAP;
            GAP: begin
                state_d = WAIT;
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
                cnt_d   = 32'd0;
`endif
            end
            WAIT: begin
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 32'd1;
`endif
                if (pg_rdy) begin
                    res_d   = pg_res;
                    err_d   = pg_err;
                    state_d = RESP;
                end
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
                else if (cnt_d == TIMEOUT_CNT) begin
                    res_d   = {W{1'b0}};
                    err_d   = 1'b1;
                    state_d = RESP;
                end
`endif
                else begin
                    state_d = WAIT;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        go_d   = (state_d == ISSUE);
        busy_d = (state_d != IDLE);
        if (state_d == RESP) begin
            done_d = ONE_HOT << idx_d;
        end else begin
            done_d = {N{1'b0}};
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= {IW{1'b0}};
            ptr_q   <= PTR_RST;
            res_q   <= {W{1'b0}};
            err_q   <= 1'b0;
            done_q  <= {N{1'b0}};
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
            cnt_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            res_q   <= res_d;
            err_q   <= err_d;
            done_q  <= done_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign done    = done_q;
    assign res_out = res_q;
    assign err_out = err_q;
    assign busy    = busy_q;
    assign pg_go   = go_q;

endmodule

// File: tb/tb_primogen_arb.sv
// Self-checking bench for primogen_arb with a behavioural primogen model and a
// transaction-level round-robin scoreboard.
module tb_primogen_arb;

    localparam int N       = 4;
    localparam int W       = 16;
    localparam int COMPUTE = 10;
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
    localparam int TMO = 20;
`else
    localparam int TMO = 1000000;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] done;
    logic [W-1:0] res_out;
    logic         err_out, busy, pg_go;
    logic         pg_rdy, pg_err;
    logic [W-1:0] pg_res;

    always #5 clk = ~clk;

    primogen_arb #(.N(N), .W(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done), .res_out(res_out),
        .err_out(err_out), .busy(busy), .pg_go(pg_go),
        .pg_rdy(pg_rdy), .pg_err(pg_err), .pg_res(pg_res)
    );

    // Behavioural primogen: ready drops when go is seen, result after COMPUTE cycles.
    int           primes[512];
    int           m_cnt, m_k;
    logic         m_rdy;
    logic [W-1:0] m_res;
    logic         force_err = 1'b0;
    logic         hang = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_rdy <= 1'b1; m_cnt <= 0; m_k <= 0; m_res <= '0;
        end else if (pg_go) begin
            m_rdy <= 1'b0; m_cnt <= COMPUTE;
        end else if (m_cnt == 1) begin
            m_cnt <= 0;
            if (!hang) begin
                m_rdy <= 1'b1; m_res <= W'(primes[m_k % 512]); m_k <= m_k + 1;
            end
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end
    end

    assign pg_rdy = force_err ? 1'b1 : m_rdy;
    assign pg_err = force_err;
    assign pg_res = m_res;

    logic [N-1:0] req_e;
    logic         rdy_e;
    always @(posedge clk) begin
        req_e <= req;
        rdy_e <= pg_rdy;
    end

    // Scoreboard state
    int           checks = 0, errors = 0;
    int           ref_ptr, prime_k, go_cnt, go_adj, go_bad, max_wait;
    logic         go_prev;
    logic [N-1:0] done_seen;
    int           waits[N];
    int           exp_idx[$];
    int           exp_res[$];
    logic [N-1:0] got_done[$];
    logic [W-1:0] got_res[$];
    logic         got_err[$];

    function automatic int rr_ref(input int p, input logic [N-1:0] r);
        for (int i = 1; i <= N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // One cycle: observe at negedge, update the reference, release finished requesters.
    task automatic step();
        int s;
        @(negedge clk);
        if (pg_go === 1'b1) begin
            go_cnt++;
            if (go_prev) go_adj++;
            if (rdy_e !== 1'b1) go_bad++;
            s = rr_ref(ref_ptr, req_e);
            exp_idx.push_back(s);
            exp_res.push_back(primes[prime_k % 512]);
            prime_k++;
            if (s >= 0) ref_ptr = s;
        end
        go_prev   = (pg_go === 1'b1);
        done_seen = done;
        if (done !== '0) begin
            got_done.push_back(done); got_res.push_back(res_out); got_err.push_back(err_out);
            for (int k = 0; k < N; k++) begin
                if (done[k]) waits[k] = 0;
                else if (req[k]) begin
                    waits[k]++;
                    if (waits[k] > max_wait) max_wait = waits[k];
                end
            end
            req = req & ~done;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        @(negedge clk);
        rst = 1'b0;
        ref_ptr = N - 1; prime_k = 0; go_cnt = 0; go_adj = 0; go_bad = 0;
        go_prev = 1'b0; max_wait = 0; done_seen = '0;
        for (int k = 0; k < N; k++) waits[k] = 0;
        exp_idx.delete(); exp_res.delete(); got_done.delete(); got_res.delete(); got_err.delete();
    endtask

    task automatic drain();
        int n = 0;
        while (req != '0 && n < 500) begin step(); n++; end
        repeat (3) step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done got=%b exp=0000", done); end
        checks++; if (res_out !== 16'd0) begin errors++; $display("FAIL reset_res got=%0d exp=0", res_out); end
        checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (pg_go !== 1'b0) begin errors++; $display("FAIL reset_go got=%b exp=0", pg_go); end
    endtask

    task automatic test_single();
        int n = 0;
        do_reset();
        req = 4'b0001;
        while (got_done.size() < 1 && n < 200) begin step(); n++; end
        checks++; if (got_done.size() != 1) begin errors++; $display("FAIL single_done_cnt got=%0d exp=1", got_done.size()); end
        else begin
            checks++; if (got_done[0] !== 4'b0001) begin errors++; $display("FAIL single_done got=%b exp=0001", got_done[0]); end
            checks++; if (got_res[0] !== 16'd2) begin errors++; $display("FAIL single_res got=%0d exp=2", got_res[0]); end
            checks++; if (got_err[0] !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", got_err[0]); end
            // go at cycle 1, ready back after COMPUTE cycles, captured then reported
            checks++; if (n != COMPUTE + 3) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", n, COMPUTE + 3); end
        end
        repeat (30) step();
        checks++; if (go_cnt != 1) begin errors++; $display("FAIL single_go_cnt got=%0d exp=1", go_cnt); end
        checks++; if (got_done.size() != 1) begin errors++; $display("FAIL single_extra_done got=%0d exp=1", got_done.size()); end
    endtask

    task automatic test_concurrent();
        int n = 0;
        int pr[4] = '{2, 3, 5, 7};
        do_reset();
        req = 4'b1111;
        while (got_done.size() < 4 && n < 400) begin step(); n++; end
        repeat (5) step();
        checks++; if (got_done.size() != 4) begin errors++; $display("FAIL conc_done_cnt got=%0d exp=4", got_done.size()); end
        for (int i = 0; i < 4 && i < got_done.size(); i++) begin
            checks++;
            if (got_done[i] !== (4'b0001 << i) || int'(got_res[i]) != pr[i] || got_err[i] !== 1'b0) begin
                errors++; $display("FAIL conc_order[%0d] got done=%b res=%0d err=%b exp done=%b res=%0d err=0",
                                   i, got_done[i], got_res[i], got_err[i], 4'b0001 << i, pr[i]);
            end
        end
        checks++; if (go_cnt != 4) begin errors++; $display("FAIL conc_go_cnt got=%0d exp=4", go_cnt); end
        checks++; if (go_adj != 0) begin errors++; $display("FAIL conc_go_adjacent got=%0d exp=0", go_adj); end
        checks++; if (go_bad != 0) begin errors++; $display("FAIL conc_go_no_rdy got=%0d exp=0", go_bad); end
    endtask

    task automatic test_fairness();
        int  n = 0, base, seen;
        logic re1 = 1'b0, got3 = 1'b0;
        do_reset();
        req = 4'b0010;
        while (got_done.size() < 1 && n < 100) begin step(); n++; end
        step();
        req[1] = 1'b1;
        repeat (3) step();
        req[3] = 1'b1;
        base = got_done.size(); seen = base; n = 0;
        while (!got3 && n < 300) begin
            step(); n++;
            if (re1) begin req[1] = 1'b1; re1 = 1'b0; end
            if (got_done.size() > seen) begin
                seen++;
                if (got_done[seen-1] === 4'b0010) re1 = 1'b1;
                if (got_done[seen-1] === 4'b1000) got3 = 1'b1;
            end
        end
        checks++; if (!got3) begin errors++; $display("FAIL fair_served3 got=0 exp=1"); end
        checks++; if (seen - base - 1 > 1) begin errors++; $display("FAIL fair_wait got=%0d exp<=1", seen - base - 1); end
        drain();
        checks++; if (req !== '0) begin errors++; $display("FAIL fair_drain got=%b exp=0000", req); end
        checks++; if (got_done.size() != exp_idx.size()) begin errors++; $display("FAIL fair_count got=%0d exp=%0d", got_done.size(), exp_idx.size()); end
        for (int i = 0; i < got_done.size() && i < exp_idx.size(); i++) begin
            checks++;
            if (exp_idx[i] < 0 || got_done[i] !== (4'b0001 << exp_idx[i]) || int'(got_res[i]) != exp_res[i]) begin
                errors++; $display("FAIL fair_sb[%0d] got done=%b res=%0d exp idx=%0d res=%0d", i, got_done[i], got_res[i], exp_idx[i], exp_res[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int k = 0; k < N; k++) begin
                if (!req[k] && !done_seen[k] && $urandom_range(0, 7) == 0) req[k] = 1'b1;
            end
        end
        drain();
        checks++; if (req !== '0) begin errors++; $display("FAIL rand_drain got=%b exp=0000", req); end
        checks++; if (got_done.size() < 20) begin errors++; $display("FAIL rand_activity got=%0d exp>=20", got_done.size()); end
        checks++; if (got_done.size() != exp_idx.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got_done.size(), exp_idx.size()); end
        for (int i = 0; i < got_done.size() && i < exp_idx.size(); i++) begin
            checks++;
            if (exp_idx[i] < 0 || got_done[i] !== (4'b0001 << exp_idx[i]) || int'(got_res[i]) != exp_res[i] || got_err[i] !== 1'b0) begin
                errors++; $display("FAIL rand_sb[%0d] got done=%b res=%0d err=%b exp idx=%0d res=%0d", i, got_done[i], got_res[i], got_err[i], exp_idx[i], exp_res[i]);
            end
        end
        checks++; if (max_wait > N - 1) begin errors++; $display("FAIL rand_max_wait got=%0d exp<=%0d", max_wait, N - 1); end
        checks++; if (go_adj != 0) begin errors++; $display("FAIL rand_go_adjacent got=%0d exp=0", go_adj); end
        checks++; if (go_bad != 0) begin errors++; $display("FAIL rand_go_no_rdy got=%0d exp=0", go_bad); end
    endtask

    task automatic test_error();
        int n = 0, go0;
        do_reset();
        req = 4'b0001;
        while (got_done.size() < 1 && n < 100) begin step(); n++; end
        step();
        force_err = 1'b1; go0 = go_cnt; req = 4'b0100; n = 0;
        while (got_done.size() < 2 && n < 50) begin step(); n++; end
        repeat (10) step();
        checks++; if (got_done.size() != 2) begin errors++; $display("FAIL err_done_cnt got=%0d exp=2", got_done.size()); end
        else begin
            checks++; if (got_done[1] !== 4'b0100) begin errors++; $display("FAIL err_done got=%b exp=0100", got_done[1]); end
            checks++; if (got_err[1] !== 1'b1) begin errors++; $display("FAIL err_flag got=%b exp=1", got_err[1]); end
            checks++; if (got_res[1] !== 16'd2) begin errors++; $display("FAIL err_res_kept got=%0d exp=2", got_res[1]); end
            checks++; if (n != 1) begin errors++; $display("FAIL err_latency got=%0d exp=1", n); end
        end
        checks++; if (go_cnt != go0) begin errors++; $display("FAIL err_no_go got=%0d exp=%0d", go_cnt, go0); end
        force_err = 1'b0;
    endtask

    task automatic test_midreset();
        int n = 0;
        do_reset();
        req = 4'b0001;
        while (got_done.size() < 1 && n < 100) begin step(); n++; end
        step();
        req = 4'b0010;
        repeat (6) step();
        do_reset();
        checks++; if (done !== 4'b0000 || res_out !== 16'd0 || err_out !== 1'b0 || busy !== 1'b0 || pg_go !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got done=%b res=%0d err=%b busy=%b go=%b exp all 0", done, res_out, err_out, busy, pg_go);
        end
        repeat (30) step();
        checks++; if (got_done.size() != 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", got_done.size()); end
        req = 4'b1001; n = 0;
        while (got_done.size() < 2 && n < 200) begin step(); n++; end
        checks++; if (got_done.size() != 2) begin errors++; $display("FAIL midrst_cnt got=%0d exp=2", got_done.size()); end
        else begin
            checks++; if (got_done[0] !== 4'b0001 || got_res[0] !== 16'd2) begin errors++; $display("FAIL midrst_first got done=%b res=%0d exp done=0001 res=2", got_done[0], got_res[0]); end
            checks++; if (got_done[1] !== 4'b1000 || got_res[1] !== 16'd3) begin errors++; $display("FAIL midrst_second got done=%b res=%0d exp done=1000 res=3", got_done[1], got_res[1]); end
        end
        repeat (3) step();
    endtask

`ifdef PRIMOGEN_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        do_reset();
        req = 4'b0001;
        while (got_done.size() < 1 && n < 100) begin step(); n++; end
        step();
        hang = 1'b1; req = 4'b0010; n = 0;
        while (got_done.size() < 2 && n < 200) begin step(); n++; end
        checks++; if (got_done.size() != 2) begin errors++; $display("FAIL tmo_done_cnt got=%0d exp=2", got_done.size()); end
        else begin
            checks++; if (got_done[1] !== 4'b0010 || got_err[1] !== 1'b1 || got_res[1] !== 16'd0) begin
                errors++; $display("FAIL tmo_resp got done=%b err=%b res=%0d exp done=0010 err=1 res=0", got_done[1], got_err[1], got_res[1]);
            end
            checks++; if (n != TMO + 3) begin errors++; $display("FAIL tmo_latency got=%0d exp=%0d", n, TMO + 3); end
        end
        hang = 1'b0;
        do_reset();
    endtask
`endif

    initial begin
        int pn = 2, pc = 0;
        bit isp;
        while (pc < 512) begin
            isp = 1'b1;
            for (int d = 2; d * d <= pn; d++) if (pn % d == 0) isp = 1'b0;
            if (isp) begin primes[pc] = pn; pc++; end
            pn++;
        end
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_concurrent();
        test_fairness();
        test_error();
        test_midreset();
        test_random();
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
